// File: rtl/load_store_unit_if.sv
// Request/writeback channel between the execute stage and the load/store unit.
//   master : execute stage (drives requests, receives writebacks)
//   slave  : load_store_unit (accepts requests, returns writebacks)
// Signals:
//   req_valid/req_ready  request handshake, accepted when both are 1 at a rising edge
//   req_is_store         1 = store, 0 = load
//   req_addr             32-bit byte address
//   req_wdata            store data
//   req_rd               load destination register
//   wb_valid             one-cycle writeback strobe
//   wb_rd/wb_data        writeback destination and data
interface load_store_unit_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_rd;
  logic              wb_valid;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, req_rd,
    input  req_ready, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, req_rd,
    output req_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: sequences single-word loads and stores to a small memory file
// through IDLE -> SETUP -> ACCESS (-> WB for loads) and returns load data on a
// one-cycle writeback strobe.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   bus (slave)       request handshake and writeback channel
//   mem_addr          word index to the memory file
//   mem_write_data    store data to the memory file
//   mem_ldr_str_en    access strobe (one cycle, in ACCESS)
//   mem_load_en       load enable (ACCESS of a load)
//   mem_store_en      store enable (ACCESS of a store)
//   mem_read_data     memory-file read data, captured at the end of ACCESS
//   err               one-cycle pulse after a rejected request
//   load_cnt          completed loads, saturating
//   store_cnt         completed stores, saturating
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus,
  output logic [IDX_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]  mem_write_data,
  output logic               mem_ldr_str_en,
  output logic               mem_load_en,
  output logic               mem_store_en,
  input  logic [DATA_W-1:0]  mem_read_data,
  output logic               err,
  output logic [15:0]        load_cnt,
  output logic [15:0]        store_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               ready_r;
  logic               accept_s;
  logic               addr_bad_s;
  logic               is_store_r;
  logic [3:0]         rd_r;
  logic [IDX_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r;
  logic               ldr_str_en_r;
  logic               load_en_r;
  logic               store_en_r;
  logic               wb_valid_r;
  logic [3:0]         wb_rd_r;
  logic [DATA_W-1:0]  wb_data_r;
  logic               err_r;
  logic [15:0]        load_cnt_r;
  logic [15:0]        store_cnt_r;

  // ready_r is high exactly while the FSM sits in IDLE, so this is the handshake.
  assign accept_s   = bus.req_valid && ready_r;
  // Reject misaligned addresses and anything beyond the last word of the memory file.
  assign addr_bad_s = (bus.req_addr[1:0] != 2'b00) ||
                      ((bus.req_addr >> (IDX_W + 2)) != 32'd0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !addr_bad_s) begin
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: state_next_s = ST_ACCESS;
      ST_ACCESS: begin
        if (is_store_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WB;
        end
      end
      ST_WB:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Control outputs registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r      <= 1'b1;
      ldr_str_en_r <= 1'b0;
      load_en_r    <= 1'b0;
      store_en_r   <= 1'b0;
      wb_valid_r   <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      ready_r      <= (state_next_s == ST_IDLE);
      ldr_str_en_r <= (state_next_s == ST_ACCESS);
      load_en_r    <= (state_next_s == ST_ACCESS) && !is_store_r;
      store_en_r   <= (state_next_s == ST_ACCESS) && is_store_r;
      wb_valid_r   <= (state_next_s == ST_WB);
      err_r        <= accept_s && addr_bad_s;
    end
  end

  // Capture an accepted request; the memory address and data hold until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_store_r  <= 1'b0;
      rd_r        <= 4'd0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (accept_s && !addr_bad_s) begin
      is_store_r  <= bus.req_is_store;
      rd_r        <= bus.req_rd;
      mem_addr_r  <= bus.req_addr[IDX_W+1:2];
      mem_wdata_r <= bus.req_wdata;
    end
  end

  // Load data is sampled on the ACCESS -> WB edge and held between writebacks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_r <= '0;
      wb_rd_r   <= 4'd0;
    end else if ((state_r == ST_ACCESS) && !is_store_r) begin
      wb_data_r <= mem_read_data;
      wb_rd_r   <= rd_r;
    end
  end

  // Saturating completion counters, bumped on the edge that leaves the last state of an operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt_r  <= 16'd0;
      store_cnt_r <= 16'd0;
    end else begin
      if ((state_r == ST_ACCESS) && is_store_r && (store_cnt_r != 16'hFFFF)) begin
        store_cnt_r <= store_cnt_r + 16'd1;
      end
      if ((state_r == ST_WB) && (load_cnt_r != 16'hFFFF)) begin
        load_cnt_r <= load_cnt_r + 16'd1;
      end
    end
  end

  assign bus.req_ready  = ready_r;
  assign bus.wb_valid   = wb_valid_r;
  assign bus.wb_rd      = wb_rd_r;
  assign bus.wb_data    = wb_data_r;
  assign mem_addr       = mem_addr_r;
  assign mem_write_data = mem_wdata_r;
  assign mem_ldr_str_en = ldr_str_en_r;
  assign mem_load_en    = load_en_r;
  assign mem_store_en   = store_en_r;
  assign err            = err_r;
  assign load_cnt       = load_cnt_r;
  assign store_cnt      = store_cnt_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  typedef struct {
    int          cyc;
    logic [3:0]  idx;
    logic [31:0] data;
    logic [3:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ldr_str_en;
  logic        mem_load_en;
  logic        mem_store_en;
  logic        err;
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;

  logic [31:0] mem_file [16];
  logic [31:0] ref_mem  [16];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   exp_next_acc = -1;
  int   ld_total = 0;
  int   st_total = 0;
  logic [31:0] last_wb = 32'd0;

  exp_t wb_q[$];
  exp_t st_q[$];
  exp_t ld_q[$];
  int   err_q[$];

  load_store_unit_if #(.DATA_W(32)) bus();

  load_store_unit #(.DATA_W(32), .IDX_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_ldr_str_en (mem_ldr_str_en),
    .mem_load_en    (mem_load_en),
    .mem_store_en   (mem_store_en),
    .mem_read_data  (mem_read_data),
    .err            (err),
    .load_cnt       (load_cnt),
    .store_cnt      (store_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory file seen by the unit: combinational read, write on the store enable.
  assign mem_read_data = mem_file[mem_addr];
  always @(posedge clk) begin
    if (mem_store_en) mem_file[mem_addr] <= mem_write_data;
  end

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Present one request (called at a negedge) and record what the unit must do with it.
  task automatic issue(input bit st, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] rd, input bit hold);
    int budget;
    int acc;
    int gap;
    bit bad;
    logic [3:0] idx;
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    budget = 20;
    while (!bus.req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      exp_next_acc  = -1;
      return;
    end
    acc = cyc + 1;
    if (exp_next_acc >= 0) chk("accept_cycle", 32'(acc), 32'(exp_next_acc));
    bad = ((addr % 4) != 0) || (addr > 32'h3C);
    idx = 4'(addr / 4);
    if (bad) begin
      err_q.push_back(acc);
      gap = 1;
    end else if (st) begin
      st_q.push_back('{acc + 1, idx, wdata, 4'd0});
      ref_mem[idx] = wdata;
      st_total++;
      gap = 3;
    end else begin
      ld_q.push_back('{acc + 1, idx, 32'd0, 4'd0});
      wb_q.push_back('{acc + 2, 4'd0, ref_mem[idx], rd});
      ld_total++;
      gap = 4;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      exp_next_acc = acc + gap;
    end else begin
      bus.req_valid = 1'b0;
      exp_next_acc  = -1;
    end
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    chk("pending_wb",    32'(wb_q.size()),  32'd0);
    chk("pending_store", 32'(st_q.size()),  32'd0);
    chk("pending_load",  32'(ld_q.size()),  32'd0);
    chk("pending_err",   32'(err_q.size()), 32'd0);
    chk("load_cnt",  {16'd0, load_cnt},  {16'd0, sat16(ld_total)});
    chk("store_cnt", {16'd0, store_cnt}, {16'd0, sat16(st_total)});
  endtask

  // Monitor: every output event is matched against the oldest expectation of its kind.
  always @(negedge clk) begin
    exp_t e;
    if (rst && mon_en) begin
      chk("enables_exclusive", {31'd0, mem_load_en & mem_store_en}, 32'd0);
      chk("ldr_str_en", {31'd0, mem_ldr_str_en}, {31'd0, mem_load_en | mem_store_en});
      if (mem_store_en) begin
        if (st_q.size() == 0) begin
          chk("unexpected_store_en", 32'd1, 32'd0);
        end else begin
          e = st_q.pop_front();
          chk("store_cycle", 32'(cyc), 32'(e.cyc));
          chk("store_addr", {28'd0, mem_addr}, {28'd0, e.idx});
          chk("store_data", mem_write_data, e.data);
        end
      end
      if (mem_load_en) begin
        if (ld_q.size() == 0) begin
          chk("unexpected_load_en", 32'd1, 32'd0);
        end else begin
          e = ld_q.pop_front();
          chk("load_cycle", 32'(cyc), 32'(e.cyc));
          chk("load_addr", {28'd0, mem_addr}, {28'd0, e.idx});
        end
      end
      if (bus.wb_valid) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_wb_valid", 32'd1, 32'd0);
        end else begin
          e = wb_q.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(e.cyc));
          chk("wb_rd", {28'd0, bus.wb_rd}, {28'd0, e.rd});
          chk("wb_data", bus.wb_data, e.data);
          last_wb = e.data;
        end
      end else begin
        chk("wb_data_hold", bus.wb_data, last_wb);
      end
      if (err) begin
        if (err_q.size() == 0) begin
          chk("unexpected_err", 32'd1, 32'd0);
        end else begin
          chk("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_file[i] = 32'hA500_0000 | 32'(i);
      ref_mem[i]  = 32'hA500_0000 | 32'(i);
    end
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.req_rd       = 4'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_mem_addr",   {28'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata",  mem_write_data, 32'd0);
    chk("rst_enables",    {29'd0, mem_ldr_str_en, mem_load_en, mem_store_en}, 32'd0);
    chk("rst_wb_valid",   {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wb_rd",      {28'd0, bus.wb_rd}, 32'd0);
    chk("rst_wb_data",    bus.wb_data, 32'd0);
    chk("rst_err",        {31'd0, err}, 32'd0);
    chk("rst_counters",   {load_cnt, store_cnt}, 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    // Store then load of the same word.
    issue(1'b1, 32'h14, 32'hDEADBEEF, 4'd3, 1'b0);
    issue(1'b0, 32'h14, 32'd0, 4'd3, 1'b0);
    drain();

    // Misaligned and out-of-range requests are rejected.
    issue(1'b0, 32'h06, 32'd0, 4'd1, 1'b0);
    issue(1'b1, 32'h40, 32'h1234_5678, 4'd1, 1'b0);
    drain();

    // First and last word.
    issue(1'b0, 32'h00, 32'd0, 4'd1, 1'b0);
    issue(1'b0, 32'h3C, 32'd0, 4'd15, 1'b0);
    drain();

    // req_valid held across three loads.
    issue(1'b0, 32'h08, 32'd0, 4'd4, 1'b1);
    issue(1'b0, 32'h14, 32'd0, 4'd5, 1'b1);
    issue(1'b0, 32'h3C, 32'd0, 4'd6, 1'b0);
    drain();

    // Random mix of loads, stores and rejects, with and without held valid.
    for (int i = 0; i < 150; i++) begin
      int unsigned r;
      logic [31:0] a;
      bit hold;
      r = $urandom_range(0, 9);
      if (r < 8) a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else a = $urandom() | 32'h40;
      hold = ($urandom_range(0, 1) == 1);
      issue($urandom_range(0, 1) == 1, a, $urandom(), 4'($urandom_range(0, 15)), hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    exp_next_acc  = -1;
    drain();

    // Saturation: preload the store counter near the top, then keep storing.
    force dut.store_cnt_r = 16'hFFFD;
    @(negedge clk);
    release dut.store_cnt_r;
    st_total = 65533;
    issue(1'b1, 32'h20, 32'h0000_0001, 4'd0, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) issue(1'b1, 32'h24, 32'(i), 4'd0, 1'b1);
    bus.req_valid = 1'b0;
    exp_next_acc  = -1;
    drain();

    // Reset during ACCESS of a load.
    issue(1'b0, 32'h08, 32'd0, 4'd2, 1'b0);
    @(negedge clk);
    chk("access_before_rst", {31'd0, mem_ldr_str_en}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_drops_ldr_str_en", {31'd0, mem_ldr_str_en}, 32'd0);
    chk("rst_drops_load_en", {31'd0, mem_load_en}, 32'd0);
    chk("rst_clears_counters", {load_cnt, store_cnt}, 32'd0);
    wb_q.delete();
    st_q.delete();
    ld_q.delete();
    err_q.delete();
    ld_total = 0;
    st_total = 0;
    last_wb  = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_mid_rst", {31'd0, bus.req_ready}, 32'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter IDX_W, default 4, SHALL set the memory word-index width (16 words).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  execute stage presents a request.
REQ-007 req_ready  out  1  unit can accept a request.
REQ-008 req_is_store  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  32  byte address from the ALU.
REQ-010 req_wdata  in  DATA_W  store data.
REQ-011 req_rd  in  4  load destination register.
REQ-012 mem_addr  out  IDX_W  word index to the memory file.
REQ-013 mem_write_data  out  DATA_W  store data to the memory file.
REQ-014 mem_ldr_str_en, mem_load_en, mem_store_en  out  1 each  memory-file enables.
REQ-015 mem_read_data  in  DATA_W  memory-file read data.
REQ-016 wb_valid  out  1  one-cycle writeback strobe.
REQ-017 wb_rd  out  4  writeback destination register.
REQ-018 wb_data  out  DATA_W  writeback data.
REQ-019 err  out  1  one-cycle pulse on a rejected request.
REQ-020 load_cnt, store_cnt  out  16 each  completed-operation counters.

Function
REQ-021 The FSM SHALL have states IDLE, SETUP, ACCESS and WB.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-023 On accept, the unit SHALL register is_store, word index req_addr[IDX_W+1:2], req_wdata and req_rd.
REQ-024 A request with req_addr[1:0] != 0, or any bit of req_addr[31:IDX_W+2] set, SHALL be rejected:
- err = 1 for the next cycle only.
- FSM stays in IDLE.
- No memory enable asserts.
- Counters unchanged.
REQ-025 An accepted valid request SHALL go IDLE -> SETUP, with mem_addr and mem_write_data driven from registers and all enables 0.
REQ-026 SETUP -> ACCESS unconditionally; in ACCESS, mem_ldr_str_en = 1, mem_store_en = is_store and mem_load_en = !is_store, for exactly one cycle.
REQ-027 mem_addr and mem_write_data SHALL stay stable from SETUP through the cycle after ACCESS.
REQ-028 Store: ACCESS -> IDLE, and store_cnt increments at that edge.
REQ-029 Load: the ACCESS -> WB edge SHALL capture mem_read_data into wb_data; in WB, wb_valid = 1 and wb_rd = the registered rd; WB -> IDLE and load_cnt increments at that edge.
REQ-030 Latency from the accept edge:
- Load: wb_valid high in the 3rd cycle; req_ready high again in the 4th cycle.
- Store: req_ready high again in the 3rd cycle.
REQ-031 A request is never accepted outside IDLE; req_valid held during busy cycles SHALL be accepted on the first IDLE cycle.
REQ-032 wb_data SHALL hold its last value when wb_valid = 0.
REQ-033 The counters SHALL saturate at 16'hFFFF, not wrap.
REQ-034 mem_load_en and mem_store_en SHALL never both be 1.

Reset
REQ-035 While rst = 0, asynchronously:
- FSM = IDLE.
- All enables, wb_valid and err = 0.
- mem_addr, mem_write_data, wb_rd, wb_data, load_cnt and store_cnt = 0.
REQ-036 Reset asserted mid-operation SHALL drop the memory enables immediately (same cycle) and discard the operation without counting it.
REQ-037 After rst rises, req_ready SHALL be 1 on the first clock.

Verification
REQ-038 Store then load: store addr 0x14, data 0xDEADBEEF, rd 3 -> mem_store_en for one cycle with mem_addr 5; then load addr 0x14 -> wb_valid in 3rd cycle with wb_data 0xDEADBEEF, wb_rd 3; store_cnt = 1, load_cnt = 1.
REQ-039 Misaligned and out of range: addr 0x06 -> err one cycle, no enables, counters 0; addr 0x40 -> same.
REQ-040 Back-to-back: req_valid held high with 3 loads -> each accepted only in IDLE; exactly three wb_valid pulses, 4 cycles apart.
REQ-041 Reset mid-access: rst = 0 during ACCESS -> mem_ldr_str_en falls before the next edge; counters 0; no wb_valid after release.
REQ-042 Saturation: force 65536 stores -> store_cnt stays 16'hFFFF.
REQ-043 Boundary: loads at addr 0x00 and 0x3C -> mem_addr 0 and 15, correct data returned.
